// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller: synchronizes IRQ lines, latches pending events, and raises a
// single prioritized request to the CPU FSM, then tracks the in-service source until mret.
module otter_intr_ctrl #(
    parameter int unsigned N_SRC = 4
) (
    input  logic             clk,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic             MIE,
    input  logic             INT_TAKEN,
    input  logic             mret_exec,
    input  logic             CFG_WE,
    input  logic [1:0]       CFG_ADDR,
    input  logic [31:0]      CFG_WD,
    output logic [31:0]      CFG_RD,
    output logic             INTR,
    output logic [2:0]       INT_ID,
    output logic             ACTIVE
);

    localparam int unsigned ID_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] s1, s2, s2_d;
    logic [N_SRC-1:0] enable, mode, pending;
    logic [N_SRC-1:0] elig, id_oh, w1c, edge_clr, pend_nxt;
    logic [ID_W-1:0]  sel_id;
    logic             cur_elig;
    logic             taken_req;
    logic             unused_wd;

    assign unused_wd = ^CFG_WD[31:N_SRC];

    assign elig      = pending & enable;
    assign taken_req = (state == REQ) && INT_TAKEN;
    assign w1c       = (CFG_WE && (CFG_ADDR == 2'd2)) ? CFG_WD[N_SRC-1:0] : '0;
    assign edge_clr  = w1c | (taken_req ? id_oh : '0);
    assign cur_elig  = |(elig & id_oh);

    // Level sources mirror the synchronized line; edge sources latch until cleared, set wins.
    assign pend_nxt = (mode & s2) | (~mode & ((s2 & ~s2_d) | (pending & ~edge_clr)));

    // Lowest eligible index wins; one-hot of the held ID for pending clear and withdraw.
    always_comb begin
        sel_id = '0;
        id_oh  = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (elig[i]) sel_id = ID_W'(i);
        end
        for (int i = 0; i < int'(N_SRC); i++) begin
            id_oh[i] = (INT_ID == ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            s1      <= '0;
            s2      <= '0;
            s2_d    <= '0;
            pending <= '0;
            enable  <= '0;
            mode    <= '0;
        end else begin
            s1      <= IRQ_IN;
            s2      <= s1;
            s2_d    <= s2;
            pending <= pend_nxt;
            if (CFG_WE && (CFG_ADDR == 2'd0)) enable <= CFG_WD[N_SRC-1:0];
            if (CFG_WE && (CFG_ADDR == 2'd1)) mode   <= CFG_WD[N_SRC-1:0];
        end
    end

    // Request/service FSM; INT_TAKEN outranks a withdraw while requesting.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            INTR   <= 1'b0;
            ACTIVE <= 1'b0;
            INT_ID <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MIE && (|elig)) begin
                        state  <= REQ;
                        INT_ID <= sel_id;
                        INTR   <= 1'b1;
                    end
                end
                REQ: begin
                    if (INT_TAKEN) begin
                        state  <= SERVICE;
                        INTR   <= 1'b0;
                        ACTIVE <= 1'b1;
                    end else if (!MIE || !cur_elig) begin
                        state <= IDLE;
                        INTR  <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (mret_exec) begin
                        state  <= IDLE;
                        ACTIVE <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    INTR   <= 1'b0;
                    ACTIVE <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        CFG_RD = '0;
        case (CFG_ADDR)
            2'd0:    CFG_RD = 32'(enable);
            2'd1:    CFG_RD = 32'(mode);
            2'd2:    CFG_RD = 32'(pending);
            default: CFG_RD = {15'd0, INTR, 5'd0, INT_ID, 6'd0, 2'(state)};
        endcase
    end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Scoreboarded bench for otter_intr_ctrl: a behavioural model predicts register and request
// state each edge; a negedge monitor compares it against the DUT outputs and read port.
module tb_otter_intr_ctrl;

    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_in;
    logic          mie, int_taken, mret_exec, cfg_we;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_wd, cfg_rd;
    logic          intr, active;
    logic [2:0]    int_id;

    always #5 clk = ~clk;

    otter_intr_ctrl #(.N_SRC(N)) dut (
        .clk       (clk),
        .RST_N     (rst_n),
        .IRQ_IN    (irq_in),
        .MIE       (mie),
        .INT_TAKEN (int_taken),
        .mret_exec (mret_exec),
        .CFG_WE    (cfg_we),
        .CFG_ADDR  (cfg_addr),
        .CFG_WD    (cfg_wd),
        .CFG_RD    (cfg_rd),
        .INTR      (intr),
        .INT_ID    (int_id),
        .ACTIVE    (active)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] en;
        logic [7:0] mode;
        logic [7:0] pend;
        logic [1:0] st;     // 0 idle, 1 requesting, 2 in service
        logic [2:0] id;
    } exp_t;

    exp_t         sb_q[$];
    logic [N-1:0] smp[$];   // IRQ samples taken at each edge, newest first
    logic [7:0]   m_en, m_mode, m_pend;
    int           m_st, m_id;

    function automatic void model_reset();
        m_en = '0; m_mode = '0; m_pend = '0; m_st = 0; m_id = 0;
        smp.delete();
        repeat (3) smp.push_back('0);
        sb_q.delete();
    endfunction

    function automatic void model_step();
        logic [N-1:0] s2o, s2do, elig, w1c, np;
        int sel, nst, nid;
        exp_t e;
        s2o  = smp[1];
        s2do = smp[2];
        elig = m_pend[N-1:0] & m_en[N-1:0];
        sel  = -1;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) sel = i;
        w1c = (cfg_we && cfg_addr == 2'd2) ? cfg_wd[N-1:0] : '0;
        for (int i = 0; i < N; i++) begin
            if (m_mode[i])                np[i] = s2o[i];
            else if (s2o[i] && !s2do[i])  np[i] = 1'b1;
            else if (w1c[i] || (m_st == 1 && int_taken && m_id == i)) np[i] = 1'b0;
            else                          np[i] = m_pend[i];
        end
        nst = m_st; nid = m_id;
        case (m_st)
            0: if (mie && sel >= 0) begin nst = 1; nid = sel; end
            1: if (int_taken) nst = 2;
               else if (!mie || !elig[m_id]) nst = 0;
            default: if (mret_exec) nst = 0;
        endcase
        if (cfg_we && cfg_addr == 2'd0) m_en   = 8'(cfg_wd[N-1:0]);
        if (cfg_we && cfg_addr == 2'd1) m_mode = 8'(cfg_wd[N-1:0]);
        m_pend = 8'(np);
        m_st = nst; m_id = nid;
        smp.push_front(irq_in);
        void'(smp.pop_back());
        e.en = m_en; e.mode = m_mode; e.pend = m_pend; e.st = 2'(m_st); e.id = 3'(m_id);
        sb_q.push_back(e);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        logic [31:0] exp_rd, act_rd;
        forever begin
            @(negedge clk);
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("intr", 32'(intr), 32'(e.st == 2'd1));
                check("active", 32'(active), 32'(e.st == 2'd2));
                if (e.st != 2'd0) check("int_id", 32'(int_id), 32'(e.id));
                case (cfg_addr)
                    2'd0:    exp_rd = 32'(e.en);
                    2'd1:    exp_rd = 32'(e.mode);
                    2'd2:    exp_rd = 32'(e.pend);
                    default: exp_rd = {15'd0, e.st == 2'd1, 5'd0, e.id, 6'd0, e.st};
                endcase
                act_rd = cfg_rd;
                if (cfg_addr == 2'd3 && e.st == 2'd0) begin
                    exp_rd = exp_rd & ~32'h700;
                    act_rd = act_rd & ~32'h700;
                end
                check("cfg_rd", act_rd, exp_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wd = d;
        tick(1);
        cfg_we = 1'b0; cfg_wd = '0;
    endtask

    task automatic pulse_taken();
        int_taken = 1'b1; tick(1); int_taken = 1'b0;
    endtask

    task automatic pulse_mret();
        mret_exec = 1'b1; tick(1); mret_exec = 1'b0;
    endtask

    task automatic wait_intr(input int max);
        int k = 0;
        while (!intr && k < max) begin
            tick(1);
            k++;
        end
        check("wait_intr", 32'(intr), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; irq_in = '0; mie = 1'b0; int_taken = 1'b0; mret_exec = 1'b0;
        cfg_we = 1'b0; cfg_addr = 2'd3; cfg_wd = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // single edge source, 4-edge latency
        cfg_write(2'd0, 32'h1);
        mie = 1'b1;
        irq_in = 4'b0001;
        tick(3);
        check("latency_early", 32'(intr), 32'd0);
        tick(1);
        check("latency", 32'(intr), 32'd1);
        check("single_id", 32'(int_id), 32'd0);
        irq_in = '0;
        cfg_addr = 2'd2;
        pulse_taken();
        check("taken_active", 32'(active), 32'd1);
        check("taken_pend", cfg_rd, 32'd0);
        tick(2);
        pulse_mret();
        check("mret_active", 32'(active), 32'd0);
        tick(2);

        // priority, no nesting, back-to-back
        cfg_write(2'd0, 32'hF);
        irq_in = 4'b0110;
        tick(1);
        irq_in = '0;
        wait_intr(10);
        check("prio_id", 32'(int_id), 32'd1);
        cfg_addr = 2'd2;
        pulse_taken();
        check("prio_pend", cfg_rd, 32'h4);
        tick(2);
        pulse_mret();
        check("b2b_gap", 32'(intr), 32'd0);
        tick(1);
        check("b2b_intr", 32'(intr), 32'd1);
        check("b2b_id", 32'(int_id), 32'd2);
        pulse_taken();
        pulse_mret();
        tick(2);

        // W1C withdraw
        irq_in = 4'b0100;
        tick(1);
        irq_in = '0;
        wait_intr(10);
        cfg_write(2'd2, 32'h4);
        check("w1c_hold", 32'(intr), 32'd1);
        tick(1);
        check("w1c_withdraw", 32'(intr), 32'd0);
        tick(2);

        // MIE withdraw and re-request
        irq_in = 4'b1000;
        tick(1);
        irq_in = '0;
        wait_intr(10);
        check("src3_id", 32'(int_id), 32'd3);
        mie = 1'b0;
        tick(1);
        check("mie_withdraw", 32'(intr), 32'd0);
        cfg_addr = 2'd2;
        #1;
        check("pend3_kept", cfg_rd & 32'h8, 32'h8);
        tick(3);
        mie = 1'b1;
        wait_intr(10);
        check("src3_again", 32'(int_id), 32'd3);
        pulse_taken();
        pulse_mret();
        tick(2);

        // level mode
        cfg_write(2'd1, 32'h2);
        irq_in = 4'b0010;
        wait_intr(10);
        check("lvl_id", 32'(int_id), 32'd1);
        pulse_taken();
        tick(2);
        pulse_mret();
        wait_intr(10);
        check("lvl_again", 32'(int_id), 32'd1);
        irq_in = '0;
        tick(4);
        check("lvl_withdraw", 32'(intr), 32'd0);
        cfg_write(2'd1, 32'h0);
        tick(2);

        // new edge and INT_TAKEN on the same edge: set wins
        irq_in = 4'b0001;
        tick(1);
        irq_in = '0;
        wait_intr(10);
        irq_in = 4'b0001;
        tick(2);
        int_taken = 1'b1;
        cfg_addr = 2'd2;
        tick(1);
        int_taken = 1'b0;
        check("set_wins", cfg_rd & 32'h1, 32'h1);
        irq_in = '0;
        tick(2);
        pulse_mret();
        wait_intr(10);
        pulse_taken();
        pulse_mret();
        tick(3);

        // asynchronous reset mid-request
        irq_in = 4'b0001;
        tick(1);
        irq_in = '0;
        wait_intr(10);
        cfg_addr = 2'd0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_id", 32'(int_id), 32'd0);
        check("rst_enable", cfg_rd, 32'd0);
        cfg_addr = 2'd2;
        #1;
        check("rst_pend", cfg_rd, 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(8);
        check("post_rst_idle", 32'(intr), 32'd0);

        // randomized traffic
        cfg_write(2'd0, 32'hF);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
            mie       = ($urandom_range(15) != 0);
            int_taken = (m_st == 1) && ($urandom_range(3) == 0);
            mret_exec = (m_st == 2) && ($urandom_range(4) == 0);
            cfg_we    = ($urandom_range(9) == 0);
            cfg_addr  = 2'($urandom_range(3));
            cfg_wd    = $urandom;
            tick(1);
        end
        cfg_we = 1'b0; int_taken = 1'b0; mret_exec = 1'b0; irq_in = '0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_intr_ctrl.md
# otter_intr_ctrl

Interrupt controller for the OTTER MCU: the request side of the trap interface whose acknowledge side lives in the CSR file and CPU control FSM. It synchronizes external interrupt lines and latches edge events as pending. It applies a software enable mask and raises a single prioritized INTR to the CPU FSM, gated by the core's MIE bit. It tracks the in-service source from INT_TAKEN until mret_exec and exposes its configuration and status through a small MMIO register window.

## Interface
- N_SRC, 4 — number of interrupt sources, 1..8; source 0 has the highest priority.
- clk  in  1  — single clock; all flops on rising edge.
- RST_N  in  1  — asynchronous, active-low reset.
- IRQ_IN  in  N_SRC  — raw asynchronous external interrupt lines.
- MIE  in  1  — global interrupt enable, driven from MSTATUS[3].
- INT_TAKEN  in  1  — 1-cycle pulse from the CPU FSM when it enters the trap.
- mret_exec  in  1  — 1-cycle pulse when mret executes.
- CFG_WE  in  1  — register write strobe.
- CFG_ADDR  in  2  — register select.
- CFG_WD  in  32  — write data.
- CFG_RD  out  32  — combinational read data.
- INTR  out  1  — registered interrupt request to the CPU FSM.
- INT_ID  out  3  — registered ID of the requested or in-service source; valid while INTR or ACTIVE is high.
- ACTIVE  out  1  — registered; high while a handler is in service.

## Operation
- Synchronizer: each IRQ_IN bit passes through 2 flops (s1, s2), then a third flop s2_d for edge detection. All reset to 0.
- MODE[i]=0 (edge): a rising edge (s2 & ~s2_d) sets PENDING[i]. The bit clears on INT_TAKEN for that ID, or on a software write-1-clear. If a set and a clear occur in the same cycle, the set wins.
- MODE[i]=1 (level): PENDING[i] follows s2 every cycle. INT_TAKEN and W1C have no effect on that bit.
- Eligible sources: ELIG = PENDING & ENABLE[N_SRC-1:0]. The selected source is the lowest set index of ELIG.
- Registers (read zero-extended):
  - 0 ENABLE: RW, reset 0.
  - 1 MODE: RW, reset 0.
  - 2 PENDING: read gives the pending bits; write 1 clears the corresponding edge-mode bits.
  - 3 STATUS: read-only. [1:0] = state, [10:8] = INT_ID, [16] = INTR. Writes are ignored.
- Bits at or above N_SRC are ignored on write.
- FSM (encoding IDLE=0, REQ=1, SERVICE=2):
  - IDLE: if MIE and ELIG≠0, capture INT_ID = selected source and go to REQ. INT_TAKEN and mret_exec are ignored.
  - REQ: INTR=1 and INT_ID is held; a higher-priority arrival does not re-select.
    - INT_TAKEN → SERVICE, and clear PENDING[INT_ID] if that source is edge-mode.
    - Otherwise, if MIE=0 or ELIG[INT_ID]=0, withdraw and go to IDLE.
    - INT_TAKEN has priority over withdraw.
  - SERVICE: INTR=0, ACTIVE=1, INT_ID is held. mret_exec → IDLE. There is no nesting: new pending sources wait.

## Timing
- All outputs are 0 on reset, and reset takes effect immediately and asynchronously.
  - This includes mid-REQ and mid-SERVICE: INTR, ACTIVE and INT_ID drop at once, and the pending bits are lost.
- Edge-source latency, with IRQ_IN rising before edge 0:
  - s1 captures the rise at edge 1 and s2 at edge 2.
  - PENDING sets at edge 3.
  - REQ is entered at edge 4, and INTR is high after edge 4 (4-cycle latency).
- Level-source latency: PENDING follows s2 with 1 extra cycle, so the latency is also 4.
- INTR falls in the cycle after the edge at which INT_TAKEN is sampled. At that same edge the PENDING bit clears and ACTIVE rises.
- Back-to-back handling: with mret_exec at edge k and another source eligible with MIE=1, REQ is re-entered at edge k+1.
- A W1C or ENABLE write that removes the requested source while in REQ causes a withdraw. It is visible 2 edges after the write: the register updates at the write edge and the FSM leaves REQ at the next edge.
- A CFG write takes effect at the clock edge; CFG_RD reflects it in the following cycle.

## Test plan
- Reset: drive RST_N low mid-REQ → INTR, ACTIVE, PENDING, ENABLE read 0 immediately. Release reset with IRQ_IN=0 → nothing requested.
- Single edge source: ENABLE=1, MIE=1, pulse IRQ_IN[0] → INTR high 4 edges later with INT_ID=0. Pulse INT_TAKEN → INTR=0, ACTIVE=1, PENDING=0. Pulse mret_exec → ACTIVE=0, FSM IDLE.
- Priority and no nesting: ENABLE=0xF, raise IRQ_IN[2] and IRQ_IN[1] simultaneously → INT_ID=1. After INT_TAKEN, PENDING=0x4. After mret_exec, INTR re-asserts 1 cycle later with INT_ID=2.
- Withdraw: with a request pending on source 3, drop MIE → INTR falls, FSM IDLE, PENDING[3] stays 1. Restore MIE → INTR re-asserts with INT_ID=3.
- Level mode: MODE=0x2, hold IRQ_IN[1] high → request. INT_TAKEN then mret_exec with the line still high → a second request follows. Lower the line while in REQ → withdraw.
- Simultaneous set and clear: a new IRQ_IN[0] edge reaches PENDING on the same edge as INT_TAKEN for ID 0 → PENDING[0]=1 afterward.
